// File: rtl/calc_pkg.sv
// Shared calculator constants: keycodes, key width and key-scheduler state encoding.
package calc_pkg;

  localparam int KEY_W = 5;

  localparam logic [KEY_W-1:0] KEY_CA      = 5'b00100;
  localparam logic [KEY_W-1:0] KEY_CE      = 5'b00101;
  localparam logic [KEY_W-1:0] KEY_ADD     = 5'b01010;
  localparam logic [KEY_W-1:0] KEY_SUB     = 5'b01011;
  localparam logic [KEY_W-1:0] KEY_MULTI   = 5'b01100;
  localparam logic [KEY_W-1:0] KEY_SQR     = 5'b01101;
  localparam logic [KEY_W-1:0] KEY_CH_SIGN = 5'b01110;
  localparam logic [KEY_W-1:0] KEY_EQUALS  = 5'b01111;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    GAP   = 2'd2
  } sched_state_t;

endpackage

// File: rtl/calc_key_sched_if.sv
// Key-source and key-stream signals between the scheduler (slave) and its environment (master).
interface calc_key_sched_if #(
  parameter int KEY_W = calc_pkg::KEY_W,
  parameter int LVL_W = 3
);
  logic [KEY_W-1:0] kp_key;
  logic             kp_valid;
  logic [KEY_W-1:0] rm_key;
  logic             rm_valid;
  logic             rm_ready;
  logic             hold;
  logic             clr_drop;
  logic [KEY_W-1:0] keycode;
  logic             newkey;
  logic [LVL_W-1:0] kp_level;
  logic             kp_drop;

  modport master (
    output kp_key, kp_valid, rm_key, rm_valid, hold, clr_drop,
    input  rm_ready, keycode, newkey, kp_level, kp_drop
  );

  modport slave (
    input  kp_key, kp_valid, rm_key, rm_valid, hold, clr_drop,
    output rm_ready, keycode, newkey, kp_level, kp_drop
  );
endinterface

// File: rtl/calc_key_fifo.sv
// Synchronous keypad FIFO; flush empties it and a same-cycle push becomes the sole entry.
module calc_key_fifo #(
  parameter  int DEPTH = 4,
  parameter  int W     = 5,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int LVL_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [W-1:0]     din,
  input  logic             pop,
  input  logic             flush,
  output logic [W-1:0]     dout,
  output logic             full,
  output logic             empty,
  output logic [LVL_W-1:0] level
);
  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (level == LVL_W'(DEPTH));
  assign empty   = (level == '0);
  assign dout    = mem[rd_ptr];
  assign do_pop  = pop && !empty;
  // A pop frees the slot the same-cycle push needs, so a full FIFO still accepts.
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= push ? PTR_W'(1) : '0;
      level  <= push ? LVL_W'(1) : '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (flush) begin
      if (push) mem[0] <= din;
    end else if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end
endmodule

// File: rtl/calc_key_sched.sv
// Merges keypad FIFO and remote holding register into one paced keycode/newkey stream.
// Optional CA flush of both sources is enabled by defining CALC_KEY_CA_FLUSH_EN.
module calc_key_sched
  import calc_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int GAP_CYCLES = 2,
  parameter int KEY_W      = calc_pkg::KEY_W
) (
  input logic              clk,
  input logic              rst_n,
  calc_key_sched_if.slave  bus
);
  localparam int LVL_W    = $clog2(FIFO_DEPTH) + 1;
  localparam int GAP_W    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam int GAP_LOAD = (GAP_CYCLES > 1) ? GAP_CYCLES - 2 : 0;

  sched_state_t     state;
  logic [GAP_W-1:0] gap_cnt;
  logic             rr_kp;
  logic             rm_full;
  logic [KEY_W-1:0] rm_reg;
  logic [KEY_W-1:0] keycode_q;
  logic             newkey_q;
  logic             drop_q;

  logic [KEY_W-1:0] fifo_dout;
  logic             fifo_full;
  logic             fifo_empty;
  logic [LVL_W-1:0] fifo_level;

  logic kp_req, rm_req, grant, pick_kp, kp_pop, rm_take, rm_accept, ca_flush, drop;

`ifdef CALC_KEY_CA_FLUSH_EN
  assign ca_flush = bus.kp_valid && (bus.kp_key == KEY_W'(KEY_CA));
`else
  assign ca_flush = 1'b0;
`endif

  assign kp_req    = !fifo_empty;
  assign rm_req    = rm_full;
  assign grant     = (state == IDLE) && !bus.hold && (kp_req || rm_req);
  assign pick_kp   = kp_req && (!rm_req || rr_kp);
  assign kp_pop    = grant && pick_kp;
  assign rm_take   = grant && !pick_kp;
  assign rm_accept = bus.rm_valid && !rm_full;
  assign drop      = bus.kp_valid && fifo_full && !kp_pop && !ca_flush;

  calc_key_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (KEY_W)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (bus.kp_valid),
    .din   (bus.kp_key),
    .pop   (kp_pop),
    .flush (ca_flush),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rm_full <= 1'b0;
      rm_reg  <= '0;
    end else if (ca_flush || rm_take) begin
      rm_full <= 1'b0;
    end else if (rm_accept) begin
      rm_full <= 1'b1;
      rm_reg  <= bus.rm_key;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_q <= 1'b0;
    end else if (drop) begin
      drop_q <= 1'b1;
    end else if (bus.clr_drop) begin
      drop_q <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      gap_cnt   <= '0;
      rr_kp     <= 1'b1;
      keycode_q <= '0;
      newkey_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          newkey_q <= 1'b0;
          if (grant) begin
            keycode_q <= pick_kp ? fifo_dout : rm_reg;
            rr_kp     <= !pick_kp;
            newkey_q  <= 1'b1;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          newkey_q <= 1'b0;
          // The IDLE arbitration cycle is the last idle cycle of the gap,
          // so GAP itself only covers GAP_CYCLES-1 cycles.
          if (GAP_CYCLES > 1) begin
            gap_cnt <= GAP_W'(GAP_LOAD);
            state   <= GAP;
          end else begin
            state <= IDLE;
          end
        end
        GAP: begin
          newkey_q <= 1'b0;
          if (gap_cnt == '0) state <= IDLE;
          else gap_cnt <= gap_cnt - GAP_W'(1);
        end
        default: begin
          newkey_q <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

  assign bus.rm_ready = !rm_full;
  assign bus.keycode  = keycode_q;
  assign bus.newkey   = newkey_q;
  assign bus.kp_level = fifo_level;
  assign bus.kp_drop  = drop_q;
endmodule
